fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the control unit in the single-cycle CPU. It owns the program counter and issues word reads to instruction memory over a req/ready/rvalid handshake. It holds the returned 32-bit instruction stable for decode and control. It advances the PC by 4, or to the branch target, when downstream acknowledges the held instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ADDR_W, 32, PC and memory address width. Fixed at 32 for this CPU.

Ports:
clock  in  1  system clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
imem_req  out  1  read request to instruction memory
imem_addr  out  32  word-aligned read address; equals pc while imem_req=1
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  read data
instruction  out  32  held instruction, feeding the control unit
instr_valid  out  1  instruction holds a fetched word
pc_out  out  32  address of held instruction
pc_plus4  out  32  pc_out+4, combinational
instr_ack  in  1  downstream consumed the held instruction
branch_taken  in  1  resolved Branch AND ALU zero for the held instruction
branch_offset  in  32  sign-extended immediate, in words

Behaviour:
- Reset (reset_n=0, asynchronous): pc=RESET_PC, instruction=32'h0, instr_valid=0, imem_req=0, imem_addr=RESET_PC, state=IDLE. Reset mid-transaction abandons the transaction; instruction memory shares reset_n, so it returns no stale response.
- States:
  - IDLE: entered only from reset; goes to REQ on the first clock edge after release.
  - REQ: imem_req=1, imem_addr=pc. On imem_ready=1, go to WAIT. Otherwise stay in REQ and keep req and addr stable.
  - WAIT: imem_req=0. On imem_rvalid=1, register instruction<=imem_rdata, set instr_valid<=1 and go to HOLD. imem_rvalid is ignored in every state except WAIT.
  - HOLD: instruction and instr_valid stay stable. On instr_ack=1, update pc<=next_pc, clear instr_valid<=0 and go to REQ.
- next_pc: pc+4+{branch_offset[29:0],2'b00} if branch_taken, else pc+4. Addition is modulo 2^32; wrap is silent (32'hFFFF_FFFC+4 gives 0).
- branch_taken and branch_offset are sampled only on the HOLD cycle where instr_ack=1. Outside that cycle they are ignored.
- instr_ack is ignored outside HOLD.
- Latency:
  - memory responding in the cycle after accept: 3 cycles per instruction (REQ, WAIT, HOLD with immediate ack);
  - first request asserted 1 cycle after reset release.
- Simultaneous events:
  - imem_ready and imem_rvalid in the same REQ cycle: rvalid is ignored (a response is never earlier than the cycle after accept).
  - branch_taken with instr_ack=0: no effect.
- instruction keeps its last value after ack; consumers must qualify it with instr_valid.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_wait_cnt[31:0].
  - perf_fetch_cnt increments on each instr_ack in HOLD.
  - perf_wait_cnt increments on every cycle spent in REQ with imem_ready=0 or in WAIT with imem_rvalid=0.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - fetch state enum {IDLE, REQ, WAIT, HOLD};
  - constants INSTR_W=32, PC_INC=32'd4, NOP_INSTR=32'h0.
- One sub-module, pc_next_calc: combinational pc+4 and branch-target adder with a select on branch_taken. It is reused by any later pipelined fetch.

Test Plan:
1. Reset release, memory ready=1, rvalid one cycle after accept, rdata=32'h8C22_0004 (lw) → imem_addr=0 on cycle 1, instr_valid=1 with instruction=32'h8C22_0004 in cycle 3, pc_out=0, pc_plus4=4.
2. Hold imem_ready=0 for 4 cycles in REQ → imem_req=1 and imem_addr stay constant; no state advance; with FETCH_PERF_EN, perf_wait_cnt=4.
3. HOLD at pc=32'h10, instr_ack=1, branch_taken=1, branch_offset=32'hFFFF_FFFE → next imem_addr=32'h0C; repeat with branch_taken=0 → 32'h14.
4. Hold instr_ack=0 for 5 cycles in HOLD while branch_taken toggles → instruction, pc_out and instr_valid unchanged, and no imem_req.
5. pc=32'hFFFF_FFFC, ack with no branch → next imem_addr=0.
6. Assert reset_n=0 asynchronously during WAIT → imem_req, instr_valid and instruction clear immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding and instruction-path constants.
package cpu_pkg;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC: sequential pc+4 or pc+4 plus a word-scaled signed branch offset.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic        [ADDR_W-1:0] pc,
    input  logic                     branch_taken,
    input  logic signed [ADDR_W-1:0] branch_offset,
    output logic        [ADDR_W-1:0] pc_plus4,
    output logic        [ADDR_W-1:0] next_pc
);

    logic signed [ADDR_W-1:0] byte_offset;

    // Offset is in words; the top two bits fall off, and all sums wrap modulo 2^ADDR_W.
    assign byte_offset = {branch_offset[ADDR_W-3:0], 2'b00};
    assign pc_plus4    = pc + PC_INC[ADDR_W-1:0];
    assign next_pc     = branch_taken ? (pc_plus4 + byte_offset) : pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads instruction memory over req/ready/rvalid and holds the word for decode.
// Optional FETCH_PERF_EN adds fetch and stall performance counters.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_plus4,
`ifdef FETCH_PERF_EN
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_wait_cnt,
`endif
    input  logic               instr_ack,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_offset
);

    fetch_state_t       state;
    fetch_state_t       state_nxt;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  next_pc;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;
    logic               capture;
    logic               take_ack;
    logic               stall;

    pc_next_calc #(
        .ADDR_W(ADDR_W)
    ) u_pc_next (
        .pc           (pc),
        .branch_taken (branch_taken),
        .branch_offset($signed(branch_offset)),
        .pc_plus4     (pc_plus4),
        .next_pc      (next_pc)
    );

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        capture   = 1'b0;
        take_ack  = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (imem_ready) state_nxt = WAIT;
                else            stall     = 1'b1;
            end
            // Responses only count here; rvalid seen in any other state is stray.
            WAIT: begin
                if (imem_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    stall = 1'b1;
                end
            end
            HOLD: begin
                if (instr_ack) begin
                    take_ack  = 1'b1;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                instr_q <= imem_rdata;
                valid_q <= 1'b1;
            end
            // Branch inputs are only meaningful on the acknowledging HOLD cycle.
            if (take_ack) begin
                pc      <= next_pc;
                valid_q <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_cnt <= 32'd0;
            perf_wait_cnt  <= 32'd0;
        end else begin
            if (take_ack) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall)    perf_wait_cnt  <= perf_wait_cnt + 32'd1;
        end
    end
`endif

    assign imem_addr   = pc;
    assign pc_out      = pc;
    assign instruction = instr_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized fetch sequences against an address/latency reference model of the fetch unit.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_ack;
    logic        branch_taken;
    logic [31:0] branch_offset;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_wait_cnt;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    int          exp_fetch;
    int          exp_wait;

    always #5 clock = ~clock;

    fetch_unit #(
        .ADDR_W  (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_wait_cnt (perf_wait_cnt),
`endif
        .instr_ack    (instr_ack),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_perf();
`ifdef FETCH_PERF_EN
        chk("perf_fetch_cnt", perf_fetch_cnt, exp_fetch);
        chk("perf_wait_cnt", perf_wait_cnt, exp_wait);
`endif
    endtask

    // One complete fetch, entered with the DUT requesting. rdly/vdly are memory stall cycles,
    // adly the cycles downstream withholds ack; the final ack uses br/off.
    task automatic do_fetch(input int rdly, input int vdly, input int adly,
                            input logic br, input logic [31:0] off, input logic [31:0] data);
        chk("req_issue", imem_req, 1);
        chk("addr_issue", imem_addr, exp_pc);
        for (int i = 0; i < rdly; i++) begin
            imem_ready  = 1'b0;
            imem_rvalid = 1'($urandom);
            instr_ack   = 1'($urandom);
            step();
            exp_wait++;
            chk("req_stall", imem_req, 1);
            chk("addr_stall", imem_addr, exp_pc);
        end
        imem_ready  = 1'b1;
        imem_rvalid = 1'($urandom);
        imem_rdata  = ~data;
        instr_ack   = 1'b0;
        step();
        imem_ready = 1'b0;
        chk("req_after_accept", imem_req, 0);
        chk("valid_in_wait", instr_valid, 0);
        for (int i = 0; i < vdly; i++) begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            step();
            exp_wait++;
            chk("valid_wait_stall", instr_valid, 0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        exp_instr   = data;
        for (int i = 0; i <= adly; i++) begin
            chk("hold_valid", instr_valid, 1);
            chk("hold_instr", instruction, exp_instr);
            chk("hold_pc", pc_out, exp_pc);
            chk("hold_pc_plus4", pc_plus4, exp_pc + 32'd4);
            chk("hold_no_req", imem_req, 0);
            if (i < adly) begin
                instr_ack     = 1'b0;
                branch_taken  = 1'($urandom);
                branch_offset = $urandom;
                imem_rvalid   = 1'($urandom);
                imem_rdata    = $urandom;
                step();
            end
        end
        instr_ack     = 1'b1;
        branch_taken  = br;
        branch_offset = off;
        imem_rvalid   = 1'b0;
        step();
        instr_ack     = 1'b0;
        branch_taken  = 1'($urandom);
        branch_offset = $urandom;
        exp_fetch++;
        exp_pc = exp_pc + 32'd4 + (br ? (off << 2) : 32'd0);
        chk("next_req", imem_req, 1);
        chk("next_addr", imem_addr, exp_pc);
        chk("valid_cleared", instr_valid, 0);
        chk("instr_retained", instruction, exp_instr);
        chk_perf();
    endtask

    initial begin
        logic [31:0] off;
        reset_n       = 1'b0;
        imem_ready    = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;
        instr_ack     = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 32'h0;
        exp_pc        = 32'h0;
        exp_instr     = 32'h0;
        exp_fetch     = 0;
        exp_wait      = 0;

        step();
        step();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk_perf();

        reset_n = 1'b1;
        chk("idle_no_req", imem_req, 0);
        step();

        // lw at address 0 with a memory that never stalls
        do_fetch(0, 0, 0, 1'b0, 32'h0, 32'h8C22_0004);
        // from pc 4 branch forward to 0x10
        do_fetch(0, 1, 0, 1'b1, 32'd2, 32'h1234_5678);
        // four REQ stall cycles, long ack delay, then branch back by two words
        do_fetch(4, 0, 5, 1'b1, 32'hFFFF_FFFE, 32'hAAAA_5555);
        chk("branch_back_addr", imem_addr, 32'h0000_000C);
        do_fetch(0, 0, 0, 1'b0, 32'h0, 32'h0BAD_F00D);
        do_fetch(1, 2, 1, 1'b0, 32'h7, 32'h0000_1111);
        chk("seq_addr", imem_addr, 32'h0000_0014);

        for (int k = 0; k < 25; k++) begin
            off = 32'($urandom_range(0, 15)) - 32'd8;
            do_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 1'($urandom), off, $urandom);
        end

        // jump to the top word, then fall through to wrap to zero
        off = (32'hFFFF_FFFC - exp_pc - 32'd4) >> 2;
        do_fetch(0, 0, 0, 1'b1, off, 32'hFEED_0001);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        do_fetch(0, 0, 1, 1'b0, 32'h0, 32'hFEED_0002);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        do_fetch(0, 0, 0, 1'b0, 32'h0, 32'hCAFE_0003);

        // accept a request, then reset asynchronously while waiting for data
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("pre_rst_req", imem_req, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_req", imem_req, 0);
        chk("async_valid", instr_valid, 0);
        chk("async_instr", instruction, 32'h0);
        chk("async_addr", imem_addr, 32'h0);
        exp_pc    = 32'h0;
        exp_fetch = 0;
        exp_wait  = 0;
        chk_perf();
        step();
        step();
        reset_n = 1'b1;
        chk("post_rst_idle", imem_req, 0);
        step();
        do_fetch(1, 1, 0, 1'b0, 32'h0, 32'h8C22_0004);
        do_fetch(0, 0, 0, 1'b0, 32'h0, 32'h0000_0013);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
